// File: rtl/safety_arm_ctrl.sv
// rtl/safety_arm_ctrl.sv - arm/fault sequencer and active limit registers for the pulse limit checker
module safety_arm_ctrl #(
  parameter int          LIMIT_W      = 32,
  parameter int          ARM_DELAY    = 16,
  parameter int          CLEAR_CYCLES = 4,
  parameter logic [31:0] DEF_PW_LO    = 32'd100,
  parameter logic [31:0] DEF_PW_HI    = 32'd1000,
  parameter logic [31:0] DEF_RATE     = 32'd100000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm_req,
  input  logic               clear_req,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_sel,
  input  logic [LIMIT_W-1:0] cfg_data,
  input  logic               pulse_lower_limit_fail,
  input  logic               pulse_upper_limit_fail,
  input  logic               rate_lower_limit_fail,
  output logic               laser_ready,
  output logic               clear_fail,
  output logic [LIMIT_W-1:0] pulse_width_lower_limit,
  output logic [LIMIT_W-1:0] pulse_width_upper_limit,
  output logic [LIMIT_W-1:0] rate_lower_limit,
  output logic [2:0]         state,
  output logic [2:0]         fault_code,
  output logic [15:0]        fault_count,
  output logic               cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMING = 3'd1,
    S_ARMED  = 3'd2,
    S_FAULT  = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

  // Counter only needs to reach ARM_DELAY-1; CLEAR_CYCLES is always smaller.
  localparam int          CW        = $clog2(ARM_DELAY);
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_DELAY - 1);
  localparam logic [CW-1:0] CLR_N    = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  state_t        state_q;
  logic [CW-1:0] cnt;
  logic [2:0]    fails;
  logic          any_fail;
  logic          limits_ok;
  logic          cfg_open;
  logic [15:0]   count_inc;

  assign fails     = {rate_lower_limit_fail, pulse_upper_limit_fail, pulse_lower_limit_fail};
  assign any_fail  = |fails;
  assign limits_ok = (pulse_width_lower_limit <= pulse_width_upper_limit);
  assign cfg_open  = (state_q == S_IDLE) || (state_q == S_FAULT);
  assign count_inc = (fault_count == 16'hFFFF) ? fault_count : fault_count + 16'd1;
  assign state     = state_q;

  // Sequencer: state, phase counter, registered gates and sticky fault record
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt         <= '0;
      laser_ready <= 1'b0;
      clear_fail  <= 1'b0;
      fault_code  <= 3'b000;
      fault_count <= 16'd0;
    end else begin
      laser_ready <= 1'b0;
      clear_fail  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arm_req && !any_fail && limits_ok) begin
            state_q    <= S_ARMING;
            cnt        <= '0;
            clear_fail <= 1'b1;
          end
        end
        S_ARMING: begin
          // Fails reported while the checker is still being cleared are stale.
          if (any_fail && (cnt >= CLR_N)) begin
            state_q     <= S_FAULT;
            fault_code  <= fault_code | fails;
            fault_count <= count_inc;
          end else if (!arm_req) begin
            state_q <= S_IDLE;
          end else if (cnt == ARM_LAST) begin
            state_q     <= S_ARMED;
            laser_ready <= 1'b1;
          end else begin
            cnt        <= cnt + 1'b1;
            clear_fail <= (cnt < CLR_LAST);
          end
        end
        S_ARMED: begin
          if (any_fail) begin
            state_q     <= S_FAULT;
            fault_code  <= fault_code | fails;
            fault_count <= count_inc;
          end else if (!arm_req) begin
            state_q <= S_IDLE;
          end else begin
            laser_ready <= 1'b1;
          end
        end
        S_FAULT: begin
          fault_code <= fault_code | fails;
          // Host must drop arm_req before a clear is honoured.
          if (clear_req && !arm_req) begin
            state_q    <= S_CLEAR;
            cnt        <= '0;
            clear_fail <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cnt == CLR_LAST) begin
            if (any_fail) begin
              state_q    <= S_FAULT;
              fault_code <= fault_code | fails;
            end else begin
              state_q    <= S_IDLE;
              fault_code <= 3'b000;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            clear_fail <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Limit registers: writable only while the laser cannot be enabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_width_lower_limit <= LIMIT_W'(DEF_PW_LO);
      pulse_width_upper_limit <= LIMIT_W'(DEF_PW_HI);
      rate_lower_limit        <= LIMIT_W'(DEF_RATE);
      cfg_err                 <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_wr) begin
        if (cfg_open && (cfg_sel != 2'd3)) begin
          case (cfg_sel)
            2'd0:    pulse_width_lower_limit <= cfg_data;
            2'd1:    pulse_width_upper_limit <= cfg_data;
            2'd2:    rate_lower_limit        <= cfg_data;
            default: cfg_err                 <= 1'b1;
          endcase
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_safety_arm_ctrl.sv
// tb/tb_safety_arm_ctrl.sv - self-checking bench for safety_arm_ctrl
module tb_safety_arm_ctrl;

  localparam int AD = 16;
  localparam int CC = 4;

  logic        clk;
  logic        rstn;
  logic        arm_req;
  logic        clear_req;
  logic        cfg_wr;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        pulse_lower_limit_fail;
  logic        pulse_upper_limit_fail;
  logic        rate_lower_limit_fail;
  logic        laser_ready;
  logic        clear_fail;
  logic [31:0] pulse_width_lower_limit;
  logic [31:0] pulse_width_upper_limit;
  logic [31:0] rate_lower_limit;
  logic [2:0]  state;
  logic [2:0]  fault_code;
  logic [15:0] fault_count;
  logic        cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  safety_arm_ctrl dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .arm_req                 (arm_req),
    .clear_req               (clear_req),
    .cfg_wr                  (cfg_wr),
    .cfg_sel                 (cfg_sel),
    .cfg_data                (cfg_data),
    .pulse_lower_limit_fail  (pulse_lower_limit_fail),
    .pulse_upper_limit_fail  (pulse_upper_limit_fail),
    .rate_lower_limit_fail   (rate_lower_limit_fail),
    .laser_ready             (laser_ready),
    .clear_fail              (clear_fail),
    .pulse_width_lower_limit (pulse_width_lower_limit),
    .pulse_width_upper_limit (pulse_width_upper_limit),
    .rate_lower_limit        (rate_lower_limit),
    .state                   (state),
    .fault_code              (fault_code),
    .fault_count             (fault_count),
    .cfg_err                 (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus cycles spent in that mode
  int          m_mode;
  int          m_age;
  int          m_count;
  logic [2:0]  m_code;
  logic [31:0] m_lim [3];
  bit          m_cfg_err;
  logic [2:0]  f;
  int          old_mode;
  int          nxt;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_mode = 0; m_age = 0; m_count = 0; m_code = 3'b000; m_cfg_err = 0;
        m_lim[0] = 32'd100; m_lim[1] = 32'd1000; m_lim[2] = 32'd100000;
      end else begin
        f = {rate_lower_limit_fail, pulse_upper_limit_fail, pulse_lower_limit_fail};
        old_mode = m_mode;
        nxt = m_mode;
        case (m_mode)
          0: if (arm_req && f == 3'b000 && m_lim[0] <= m_lim[1]) nxt = 1;
          1: if (f != 3'b000 && m_age >= CC) nxt = 3;
             else if (!arm_req) nxt = 0;
             else if (m_age == AD - 1) nxt = 2;
          2: if (f != 3'b000) nxt = 3;
             else if (!arm_req) nxt = 0;
          3: begin
               m_code = m_code | f;
               if (clear_req && !arm_req) nxt = 4;
             end
          4: if (m_age == CC - 1) nxt = (f != 3'b000) ? 3 : 0;
          default: nxt = 0;
        endcase
        if (nxt == 3 && (old_mode == 1 || old_mode == 2)) begin
          m_code = m_code | f;
          if (m_count < 65535) m_count++;
        end
        if (old_mode == 4 && nxt == 3) m_code = m_code | f;
        if (old_mode == 4 && nxt == 0) m_code = 3'b000;
        m_age = (nxt == old_mode) ? m_age + 1 : 0;
        m_cfg_err = 0;
        if (cfg_wr) begin
          if ((old_mode == 0 || old_mode == 3) && cfg_sel != 2'd3) m_lim[cfg_sel] = cfg_data;
          else m_cfg_err = 1;
        end
        m_mode = nxt;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("state", 32'(state), 32'(m_mode));
      chk("laser_ready", 32'(laser_ready), 32'(m_mode == 2));
      chk("clear_fail", 32'(clear_fail), 32'((m_mode == 1 && m_age < CC) || m_mode == 4));
      chk("pw_lo", pulse_width_lower_limit, m_lim[0]);
      chk("pw_hi", pulse_width_upper_limit, m_lim[1]);
      chk("rate_lo", rate_lower_limit, m_lim[2]);
      chk("fault_code", 32'(fault_code), 32'(m_code));
      chk("fault_count", 32'(fault_count), 32'(m_count));
      chk("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_data = d;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  int n_arming;
  int n_clr;
  bit seen;

  initial begin
    rstn = 1'b1; arm_req = 1'b0; clear_req = 1'b0; cfg_wr = 1'b0; cfg_sel = 2'd0; cfg_data = 32'd0;
    pulse_lower_limit_fail = 1'b0; pulse_upper_limit_fail = 1'b0; rate_lower_limit_fail = 1'b0;
    #1 rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(1);
    chk("lit_reset_state", 32'(state), 32'd0);
    chk("lit_reset_laser", 32'(laser_ready), 32'd0);
    chk("lit_reset_pw_lo", pulse_width_lower_limit, 32'd100);
    chk("lit_reset_pw_hi", pulse_width_upper_limit, 32'd1000);
    chk("lit_reset_rate", rate_lower_limit, 32'd100000);

    // Arm with no fails
    arm_req = 1'b1;
    n_arming = 0; n_clr = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (state == 3'd1) n_arming++;
      if (clear_fail) n_clr++;
      if (laser_ready) seen = 1;
    end
    chk("lit_armed_reached", 32'(seen), 32'd1);
    chk("lit_arming_cycles", 32'(n_arming), 32'd16);
    chk("lit_arming_clear_cycles", 32'(n_clr), 32'd4);

    // Config write rejected while armed
    cfg_write(2'd0, 32'd5);
    chk("lit_cfg_err_armed", 32'(cfg_err), 32'd1);
    chk("lit_pw_lo_unchanged", pulse_width_lower_limit, 32'd100);
    tick(1);
    chk("lit_cfg_err_drop", 32'(cfg_err), 32'd0);

    // One-cycle upper fail while armed
    pulse_upper_limit_fail = 1'b1;
    tick(1);
    pulse_upper_limit_fail = 1'b0;
    chk("lit_fault_state", 32'(state), 32'd3);
    chk("lit_fault_laser", 32'(laser_ready), 32'd0);
    chk("lit_fault_code", 32'(fault_code), 32'd2);
    chk("lit_fault_count", 32'(fault_count), 32'd1);

    // Clear while still armed is ignored
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(1);
    chk("lit_clear_ignored", 32'(state), 32'd3);

    // Disarm then clear
    arm_req = 1'b0;
    tick(1);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    n_clr = 0;
    for (int i = 0; i < 8; i++) begin
      if (clear_fail) n_clr++;
      tick(1);
    end
    chk("lit_clear_cycles", 32'(n_clr), 32'd4);
    chk("lit_clear_idle", 32'(state), 32'd0);
    chk("lit_clear_code", 32'(fault_code), 32'd0);

    // Config writes in IDLE, including reserved select
    cfg_write(2'd0, 32'd5);
    chk("lit_pw_lo_written", pulse_width_lower_limit, 32'd5);
    cfg_write(2'd3, 32'd77);
    chk("lit_cfg_err_sel3", 32'(cfg_err), 32'd1);
    cfg_write(2'd0, 32'd100);

    // Fail during clearing window ignored; disarm mid-ARMING
    arm_req = 1'b1;
    tick(2);
    pulse_lower_limit_fail = 1'b1;
    tick(1);
    pulse_lower_limit_fail = 1'b0;
    chk("lit_early_fail_ignored", 32'(state), 32'd1);
    tick(3);
    arm_req = 1'b0;
    tick(1);
    chk("lit_disarm_arming", 32'(state), 32'd0);

    // Fail after clearing window in ARMING faults
    arm_req = 1'b1;
    tick(7);
    pulse_lower_limit_fail = 1'b1;
    tick(1);
    pulse_lower_limit_fail = 1'b0;
    chk("lit_arming_fault", 32'(state), 32'd3);
    chk("lit_arming_fault_code", 32'(fault_code), 32'd1);
    chk("lit_arming_fault_count", 32'(fault_count), 32'd2);
    arm_req = 1'b0;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(6);
    chk("lit_clear2_idle", 32'(state), 32'd0);

    // Rate fail together with disarm, held through CLEAR
    arm_req = 1'b1;
    tick(20);
    rate_lower_limit_fail = 1'b1;
    arm_req = 1'b0;
    tick(1);
    chk("lit_rate_fault", 32'(state), 32'd3);
    chk("lit_rate_count", 32'(fault_count), 32'd3);
    chk("lit_rate_code", 32'(fault_code), 32'd4);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(5);
    chk("lit_refault_state", 32'(state), 32'd3);
    chk("lit_refault_count", 32'(fault_count), 32'd3);
    rate_lower_limit_fail = 1'b0;
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(5);
    chk("lit_clear3_idle", 32'(state), 32'd0);

    // Inverted pulse-width limits block arming; write on the arming edge
    cfg_write(2'd0, 32'd2000);
    arm_req = 1'b1;
    tick(5);
    chk("lit_bad_limits_idle", 32'(state), 32'd0);
    cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_data = 32'd100;
    tick(1);
    cfg_wr = 1'b0;
    chk("lit_edge_write_idle", 32'(state), 32'd0);
    chk("lit_edge_write_val", pulse_width_lower_limit, 32'd100);
    tick(1);
    chk("lit_edge_arming", 32'(state), 32'd1);
    tick(20);
    chk("lit_rearmed", 32'(laser_ready), 32'd1);

    // Asynchronous reset mid-ARMED
    #2 rstn = 1'b0;
    #1;
    chk("lit_async_laser", 32'(laser_ready), 32'd0);
    chk("lit_async_state", 32'(state), 32'd0);
    arm_req = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(1);
    chk("lit_post_reset_count", 32'(fault_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
